// File: rtl/regset_pkg.sv
// Shared definitions for the clearable register set: sequencer state encoding
// and default geometry.
package regset_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_ADDR_BITS = 6;

endpackage

// File: rtl/regset_clear_if.sv
// Decode/writeback-facing port bundle of the register set: one write port,
// two read ports, clear request and ready status.
interface regset_clear_if
    import regset_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) ();

    logic                 clear_req;
    logic                 ready;
    logic                 we;
    logic [ADDR_BITS-1:0] wa;
    logic [WIDTH-1:0]     wd;
    logic                 wg;
    logic [ADDR_BITS-1:0] ra1;
    logic [ADDR_BITS-1:0] ra2;
    logic [WIDTH-1:0]     rd1;
    logic [WIDTH-1:0]     rd2;
    logic                 rg1;
    logic                 rg2;

    modport master (
        output clear_req, we, wa, wd, wg, ra1, ra2,
        input  ready, rd1, rd2, rg1, rg2
    );

    modport slave (
        input  clear_req, we, wa, wd, wg, ra1, ra2,
        output ready, rd1, rd2, rg1, rg2
    );

endinterface

// File: rtl/regset_bank.sv
// Plain 1W2R storage array without reset or preinit so it maps onto RAM
// primitives; all masking, forwarding and output registering live above it.
module regset_bank #(
    parameter int EW        = 33,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] wa,
    input  logic [EW-1:0]        wd,
    input  logic [ADDR_BITS-1:0] ra1,
    input  logic [ADDR_BITS-1:0] ra2,
    output logic [EW-1:0]        rd1,
    output logic [EW-1:0]        rd2
);

    logic [EW-1:0] mem_r [0:(1<<ADDR_BITS)-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wa] <= wd;
        end
    end

    assign rd1 = mem_r[ra1];
    assign rd2 = mem_r[ra2];

endmodule

// File: rtl/regset_clear.sv
// Register set with clear sequencer: after reset or clear_req it sweeps all
// entries to zero before accepting writes, then serves two registered reads.
module regset_clear
    import regset_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int GRUBBY    = 1,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic          clk,
    input  logic          rstn,
    regset_clear_if.slave bus
);

    localparam int EW = WIDTH + GRUBBY;

    state_t               state_r, state_next_s;
    logic [ADDR_BITS-1:0] cnt_r, cnt_next_s;
    logic                 ready_r;

    logic                 bank_we_s;
    logic [ADDR_BITS-1:0] bank_wa_s;
    logic [EW-1:0]        bank_wd_s;
    logic [EW-1:0]        bank_rd1_s, bank_rd2_s;

    logic [EW-1:0]        wdata_ext_s;
    logic                 wr_ext_s;
    logic [EW-1:0]        rdn1_s, rdn2_s;
    logic                 rgn1_s, rgn2_s;

    logic [WIDTH-1:0]     rd1_r, rd2_r;
    logic                 rg1_r, rg2_r;

    if (GRUBBY != 0) begin : g_grubby
        assign wdata_ext_s = {bus.wg, bus.wd};
        assign rgn1_s      = rdn1_s[EW-1];
        assign rgn2_s      = rdn2_s[EW-1];
    end else begin : g_no_grubby
        assign wdata_ext_s = bus.wd;
        assign rgn1_s      = 1'b0;
        assign rgn2_s      = 1'b0;
    end

    // Selects what a read port registers: forced zero, forwarded write, or stored entry
    function automatic logic [EW-1:0] read_sel(
        input logic                 run,
        input logic [ADDR_BITS-1:0] ra,
        input logic                 wr,
        input logic [ADDR_BITS-1:0] wa,
        input logic [EW-1:0]        wdata,
        input logic [EW-1:0]        stored
    );
        logic [EW-1:0] sel;
        sel = {EW{1'b0}};
        if (!run) begin
            sel = {EW{1'b0}};
        end else if ((ZERO_REG != 0) && (ra == {ADDR_BITS{1'b0}})) begin
            sel = {EW{1'b0}};
        end else if ((BYPASS != 0) && wr && (wa == ra)) begin
            sel = wdata;
        end else begin
            sel = stored;
        end
        return sel;
    endfunction

    // External write qualification: RUN only, clear wins, entry 0 may be hardwired
    always_comb begin
        wr_ext_s = 1'b0;
        if ((state_r == ST_RUN) && bus.we && !bus.clear_req) begin
            wr_ext_s = !((ZERO_REG != 0) && (bus.wa == {ADDR_BITS{1'b0}}));
        end else begin
            wr_ext_s = 1'b0;
        end
    end

    // Clear sequencer next state and write-port mux
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        bank_we_s    = wr_ext_s;
        bank_wa_s    = bus.wa;
        bank_wd_s    = wdata_ext_s;
        case (state_r)
            ST_CLEAR: begin
                bank_we_s  = 1'b1;
                bank_wa_s  = cnt_r;
                bank_wd_s  = {EW{1'b0}};
                cnt_next_s = cnt_r + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                if (cnt_r == {ADDR_BITS{1'b1}}) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.clear_req) begin
                    state_next_s = ST_CLEAR;
                    cnt_next_s   = {ADDR_BITS{1'b0}};
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_CLEAR;
                cnt_next_s   = {ADDR_BITS{1'b0}};
                bank_we_s    = 1'b0;
            end
        endcase
    end

    // Read-port next values
    always_comb begin
        rdn1_s = read_sel(state_r == ST_RUN, bus.ra1, wr_ext_s, bus.wa, wdata_ext_s, bank_rd1_s);
        rdn2_s = read_sel(state_r == ST_RUN, bus.ra2, wr_ext_s, bus.wa, wdata_ext_s, bank_rd2_s);
    end

    // Sequencer state, sweep counter and registered ready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {ADDR_BITS{1'b0}};
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (state_next_s == ST_RUN);
        end
    end

    // Read output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd1_r <= {WIDTH{1'b0}};
            rd2_r <= {WIDTH{1'b0}};
            rg1_r <= 1'b0;
            rg2_r <= 1'b0;
        end else begin
            rd1_r <= rdn1_s[WIDTH-1:0];
            rd2_r <= rdn2_s[WIDTH-1:0];
            rg1_r <= rgn1_s;
            rg2_r <= rgn2_s;
        end
    end

    regset_bank #(
        .EW        (EW),
        .ADDR_BITS (ADDR_BITS)
    ) u_bank (
        .clk (clk),
        .we  (bank_we_s),
        .wa  (bank_wa_s),
        .wd  (bank_wd_s),
        .ra1 (bus.ra1),
        .ra2 (bus.ra2),
        .rd1 (bank_rd1_s),
        .rd2 (bank_rd2_s)
    );

    assign bus.ready = ready_r;
    assign bus.rd1   = rd1_r;
    assign bus.rd2   = rd2_r;
    assign bus.rg1   = rg1_r;
    assign bus.rg2   = rg2_r;

endmodule
